// File: rtl/bch_pkg.sv
// Shared definitions for the BCH decoder slice: default code parameters,
// the Berlekamp-Massey controller states and the GF symbol array shapes.
package bch_pkg;

    localparam int BCH_M = 4;
    localparam int BCH_T = 2;
    localparam logic [BCH_M:0] BCH_POLY = 5'b10011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } bm_state_t;

    typedef logic [BCH_M-1:0] gf_sym_t;
    typedef gf_sym_t synd_arr_t [2*BCH_T];
    typedef gf_sym_t coef_arr_t [2*BCH_T+1];

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier: shift-and-add with reduction modulo POLY.
module gf_mul
    import bch_pkg::*;
#(
    parameter int M = BCH_M,
    parameter logic [M:0] POLY = BCH_POLY
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    function automatic logic [M-1:0] mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) acc ^= sh;
            // multiply by alpha, folding the overflow bit back through POLY
            sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ POLY[M-1:0]) : {sh[M-2:0], 1'b0};
        end
        return acc;
    endfunction

    assign p = mul(a, b);

endmodule

// File: rtl/bch_bm_iter.sv
// Iterative inverse-free Berlekamp-Massey solver: one iteration per cycle over
// 2T syndromes, producing a (scaled) error-locator polynomial and its length.
module bch_bm_iter
    import bch_pkg::*;
#(
    parameter int M = BCH_M,
    parameter int T = BCH_T,
    parameter logic [M:0] POLY = BCH_POLY
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2*T*M-1:0]           synd,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(T+1)*M-1:0]         lambda,
    output logic [$clog2(2*T+1)-1:0]   deg,
    output logic                       fail
);

    localparam int N  = 2 * T;
    localparam int LW = $clog2(2 * T + 1);
    localparam logic [LW-1:0] LAST = LW'(N);
    localparam logic [LW-1:0] TMAX = LW'(T);

    bm_state_t      state;
    synd_arr_t      syn;
    coef_arr_t      lam_r;
    coef_arr_t      b_r;
    coef_arr_t      lam_nx;
    coef_arr_t      b_nx;
    coef_arr_t      s_sel;
    coef_arr_t      prod_d;
    coef_arr_t      prod_g;
    synd_arr_t      prod_b;
    gf_sym_t        gamma;
    gf_sym_t        delta;
    logic [LW-1:0]  lreg;
    logic [LW-1:0]  rcnt;
    logic           grow;

    // Pair coefficient j with S(r+1-j); terms that would need S(<1) stay zero.
    always_comb begin
        for (int j = 0; j <= N; j++) begin
            s_sel[j] = '0;
        end
        for (int j = 0; j <= N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (i + j == int'(rcnt)) s_sel[j] = syn[i];
            end
        end
    end

    for (genvar j = 0; j <= N; j++) begin : g_lam
        gf_mul #(.M(M), .POLY(POLY)) u_disc  (.a(lam_r[j]), .b(s_sel[j]), .p(prod_d[j]));
        gf_mul #(.M(M), .POLY(POLY)) u_scale (.a(gamma),    .b(lam_r[j]), .p(prod_g[j]));
    end

    for (genvar k = 0; k < N; k++) begin : g_b
        gf_mul #(.M(M), .POLY(POLY)) u_corr (.a(delta), .b(b_r[k]), .p(prod_b[k]));
    end

    always_comb begin
        delta = '0;
        for (int j = 0; j <= N; j++) begin
            if (j <= int'(lreg)) delta ^= prod_d[j];
        end
        grow = (delta != '0) && (2 * int'(lreg) <= int'(rcnt));
    end

    // lambda <= gamma*lambda + delta*x*B; B either captures old lambda or shifts up
    always_comb begin
        lam_nx[0] = prod_g[0];
        b_nx[0]   = grow ? lam_r[0] : '0;
        for (int k = 1; k <= N; k++) begin
            lam_nx[k] = prod_g[k] ^ prod_b[k-1];
            b_nx[k]   = grow ? lam_r[k] : b_r[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            lambda    <= '0;
            deg       <= '0;
            fail      <= 1'b0;
            lreg      <= '0;
            rcnt      <= '0;
            gamma     <= '0;
            for (int k = 0; k <= N; k++) begin
                lam_r[k] <= '0;
                b_r[k]   <= '0;
            end
            for (int i = 0; i < N; i++) begin
                syn[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            syn[i] <= synd[i*M +: M];
                        end
                        for (int k = 0; k <= N; k++) begin
                            lam_r[k] <= (k == 0) ? gf_sym_t'(1) : '0;
                            b_r[k]   <= (k == 0) ? gf_sym_t'(1) : '0;
                        end
                        lreg  <= '0;
                        rcnt  <= '0;
                        gamma <= gf_sym_t'(1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // One extra CALC cycle after the last iteration publishes the result.
                    if (rcnt != LAST) begin
                        lam_r <= lam_nx;
                        b_r   <= b_nx;
                        if (grow) begin
                            lreg  <= rcnt + LW'(1) - lreg;
                            gamma <= delta;
                        end
                        rcnt <= rcnt + LW'(1);
                    end else begin
                        for (int k = 0; k <= T; k++) begin
                            lambda[k*M +: M] <= lam_r[k];
                        end
                        deg       <= lreg;
                        fail      <= (lreg > TMAX);
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
